// File: rtl/spi_prog_loader.sv
// SPI flash-programming command decoder: parses address/data commands from the
// SPI byte stream and issues 32-bit instruction-memory writes over valid/ready.
module spi_prog_loader #(
    parameter logic [7:0] CMD_ADDR = 8'h01,
    parameter logic [7:0] CMD_DATA = 8'h02,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             flush,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic             busy,
    output logic             err_cmd,
    output logic             err_ovr,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_reg;
    logic [31:0] shift;
    logic [1:0]  byte_cnt;

    logic [31:0] word;
    logic        rx_take;
    logic        last_byte;
    logic        addr_done;
    logic        data_done;
    logic        handshake;

    // flush overrides any byte arriving in the same cycle
    assign rx_take   = rx_valid & ~flush;
    assign word      = {shift[23:0], rx_byte};
    assign last_byte = rx_take & (byte_cnt == 2'd3);
    assign addr_done = last_byte & (state == ADDR);
    assign data_done = last_byte & (state == DATA);
    assign handshake = mem_we & mem_ready;
    assign busy      = (state != IDLE) | mem_we;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx_byte == CMD_ADDR)      state_nxt = ADDR;
                    else if (rx_byte == CMD_DATA) state_nxt = DATA;
                end
                ADDR, DATA: begin
                    if (byte_cnt == 2'd3) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            shift    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                byte_cnt <= 2'd0;
            end else if (rx_valid) begin
                if (state == IDLE) begin
                    byte_cnt <= 2'd0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shift    <= word;
                end
            end
        end
    end

    // A freshly loaded address wins over the post-handshake increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg <= 32'd0;
        end else if (addr_done) begin
            addr_reg <= word & ~32'h3;
        end else if (handshake) begin
            addr_reg <= addr_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_we    <= 1'b0;
            err_ovr   <= 1'b0;
        end else if (data_done) begin
            if (!mem_we) begin
                mem_addr  <= addr_reg;
                mem_wdata <= word;
                mem_we    <= 1'b1;
            end else if (!mem_ready) begin
                err_ovr <= 1'b1;
            end else begin
                // previous write retires this cycle; chain the next one
                mem_addr  <= addr_reg + 32'd4;
                mem_wdata <= word;
            end
        end else if (handshake) begin
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cmd    <= 1'b0;
            word_count <= '0;
        end else begin
            if (rx_take && state == IDLE && rx_byte != CMD_ADDR && rx_byte != CMD_DATA)
                err_cmd <= 1'b1;
            if (handshake)
                word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed self-checking bench for spi_prog_loader: protocol parsing,
// back-pressure, overrun, chained writes, address wrap, flush and reset.
module tb_spi_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        flush = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        err_cmd;
    logic        err_ovr;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    spi_prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .err_cmd    (err_cmd),
        .err_ovr    (err_ovr),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; byte is captured at the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] op, input logic [31:0] w);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_we"}, 32'(mem_we), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err_cmd"}, 32'(err_cmd), 32'h0);
        check({tag, "_err_ovr"}, 32'(err_ovr), 32'h0);
        check({tag, "_count"}, 32'(word_count), 32'h0);
    endtask

    initial begin
        logic [31:0] hold_addr;
        logic [31:0] hold_data;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        mem_ready = 1'b1;

        // Basic address + data write
        send_word(8'h01, 32'h1000_0000);
        check("t1_busy_idle", 32'(busy), 32'h0);
        send_word(8'h02, 32'h0000_0013);
        check("t1_we", 32'(mem_we), 32'h1);
        check("t1_addr", mem_addr, 32'h1000_0000);
        check("t1_wdata", mem_wdata, 32'h0000_0013);
        check("t1_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("t1_we_drop", 32'(mem_we), 32'h0);
        check("t1_count", 32'(word_count), 32'd1);

        // Auto-increment
        send_word(8'h02, 32'hDEAD_BEEF);
        check("t2_addr", mem_addr, 32'h1000_0004);
        check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t2_count", 32'(word_count), 32'd2);

        // Back-pressure: outputs hold for 20 cycles
        mem_ready = 1'b0;
        send_word(8'h02, 32'hCAFE_F00D);
        hold_addr = 32'h1000_0008;
        hold_data = 32'hCAFE_F00D;
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_we", 32'(mem_we), 32'h1);
            check("t3_hold_addr", mem_addr, hold_addr);
            check("t3_hold_wdata", mem_wdata, hold_data);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("t3_we_drop", 32'(mem_we), 32'h0);
        check("t3_count", 32'(word_count), 32'd3);

        // Chained write: new word completes in the cycle the pending one is accepted
        mem_ready = 1'b0;
        send_word(8'h02, 32'hAAAA_0001);
        check("t4_first_addr", mem_addr, 32'h1000_000C);
        send_byte(8'h02);
        send_byte(8'hBB);
        send_byte(8'hBB);
        send_byte(8'h00);
        mem_ready = 1'b1;
        send_byte(8'h02);
        check("t4_chain_we", 32'(mem_we), 32'h1);
        check("t4_chain_addr", mem_addr, 32'h1000_0010);
        check("t4_chain_wdata", mem_wdata, 32'hBBBB_0002);
        check("t4_chain_count", 32'(word_count), 32'd4);
        check("t4_no_ovr", 32'(err_ovr), 32'h0);
        @(negedge clk);
        check("t4_we_drop", 32'(mem_we), 32'h0);
        check("t4_count", 32'(word_count), 32'd5);

        // Overrun: second word dropped
        mem_ready = 1'b0;
        send_word(8'h02, 32'h1111_1111);
        check("t5_ovr_clear", 32'(err_ovr), 32'h0);
        send_word(8'h02, 32'h2222_2222);
        check("t5_ovr_set", 32'(err_ovr), 32'h1);
        check("t5_addr", mem_addr, 32'h1000_0014);
        check("t5_wdata", mem_wdata, 32'h1111_1111);
        mem_ready = 1'b1;
        @(negedge clk);
        check("t5_we_drop", 32'(mem_we), 32'h0);
        check("t5_count", 32'(word_count), 32'd6);
        @(negedge clk);
        check("t5_no_second", 32'(mem_we), 32'h0);
        check("t5_count_hold", 32'(word_count), 32'd6);

        // Unknown opcode, then masked address load
        send_byte(8'h7F);
        check("t6_err_cmd", 32'(err_cmd), 32'h1);
        check("t6_idle", 32'(busy), 32'h0);
        send_word(8'h01, 32'h0000_0007);
        send_word(8'h02, 32'h1234_5678);
        check("t6_addr_masked", mem_addr, 32'h0000_0004);
        check("t6_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        check("t6_count", 32'(word_count), 32'd7);

        // Address wrap
        send_word(8'h01, 32'hFFFF_FFFC);
        send_word(8'h02, 32'h0000_AAAA);
        check("t7_top_addr", mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        send_word(8'h02, 32'h0000_BBBB);
        check("t7_wrap_addr", mem_addr, 32'h0000_0000);
        @(negedge clk);
        check("t7_count", 32'(word_count), 32'd9);
        check("t7_err_sticky", 32'(err_ovr) << 1 | 32'(err_cmd), 32'h3);

        // Reset, partial address command, flush (with a colliding byte)
        reset = 1'b1;
        #1;
        check_reset_outputs("rst2");
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h00);
        check("t8_busy_partial", 32'(busy), 32'h1);
        flush = 1'b1;
        send_byte(8'h02);
        flush = 1'b0;
        check("t8_flush_idle", 32'(busy), 32'h0);
        send_word(8'h02, 32'h0000_0001);
        check("t8_addr", mem_addr, 32'h0000_0000);
        check("t8_wdata", mem_wdata, 32'h0000_0001);
        @(negedge clk);
        check("t8_count", 32'(word_count), 32'd1);

        // Reset mid-write and mid-command
        mem_ready = 1'b0;
        send_word(8'h02, 32'hABCD_EF01);
        check("t9_we_pending", 32'(mem_we), 32'h1);
        send_byte(8'h02);
        send_byte(8'h11);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t9_async");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t9_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
